// File: rtl/toy_cache_rsp_router_pkg.sv
// toy_cache_rsp_router_pkg: response payload type and id width shared by the router and its FIFOs
package toy_cache_rsp_router_pkg;
  localparam int unsigned RSP_SRC_ID_W = 2;
  localparam int unsigned RSP_TAG_W = 4;
  typedef struct packed {
    logic [RSP_SRC_ID_W-1:0] src_id;
    logic [63:0]             rd_data;
    logic [RSP_TAG_W-1:0]    lsu_tag;
    logic [1:0]              excp;
  } cache_rsp_pkg;
endpackage

// File: rtl/toy_cache_rsp_router_fifo.sv
// toy_cache_rsp_router_fifo: per-destination FIFO of DEPTH entries of type T
//   clk, rst_n (async, active-high) | push/din write when not full | pop reads when not empty
//   full, empty, head (entry at read pointer)
module toy_cache_rsp_router_fifo
  import toy_cache_rsp_router_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type T = cache_rsp_pkg
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  T mem_q [DEPTH];
  T mem_d [DEPTH];
  logic do_push, do_pop;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem_q[rd_ptr_q];
  // Pointers wrap explicitly so DEPTH need not be a power of two
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = !do_push ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = !do_pop ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/toy_cache_rsp_router.sv
// toy_cache_rsp_router: routes one cache response stream to NUM_DST per-requester FIFOs by src_id
//   clk, rst_n (async, active-high) | s_vld/s_rdy/s_pld: cache response in
//   v_m_vld/v_m_rdy/v_m_pld: per-destination outputs | err_vld: pulse after an illegal-id drop
//   TOY_RSP_ROUTER_BYPASS_EN: empty+ready destination takes the incoming beat combinationally
module toy_cache_rsp_router
  import toy_cache_rsp_router_pkg::*;
#(
  parameter int unsigned NUM_DST = 3,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_vld,
  output logic                             s_rdy,
  input  cache_rsp_pkg                     s_pld,
  output logic         [NUM_DST-1:0]       v_m_vld,
  input  logic         [NUM_DST-1:0]       v_m_rdy,
  output cache_rsp_pkg [NUM_DST-1:0]       v_m_pld,
  output logic                             err_vld
);
  logic [RSP_SRC_ID_W-1:0] id;
  logic legal, err_q, err_d;
  logic [NUM_DST-1:0] sel, full, empty, push, pop;
  cache_rsp_pkg [NUM_DST-1:0] head;
  assign id = s_pld.src_id;
  assign legal = 32'(id) < NUM_DST;
  // sel is one-hot or zero; illegal ids select nothing and are always accepted
  assign s_rdy = ~|(sel & full);
`ifdef TOY_RSP_ROUTER_BYPASS_EN
  logic [NUM_DST-1:0] byp;
  assign byp = {NUM_DST{s_vld}} & sel & empty & v_m_rdy;
  assign push = {NUM_DST{s_vld & s_rdy}} & sel & ~byp;
  assign pop = v_m_rdy & ~empty;
  assign v_m_vld = ~empty | byp;
`else
  assign push = {NUM_DST{s_vld & s_rdy}} & sel;
  assign pop = v_m_rdy & ~empty;
  assign v_m_vld = ~empty;
`endif
  for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
    assign sel[d] = id == RSP_SRC_ID_W'(d);
`ifdef TOY_RSP_ROUTER_BYPASS_EN
    assign v_m_pld[d] = empty[d] ? s_pld : head[d];
`else
    assign v_m_pld[d] = head[d];
`endif
    toy_cache_rsp_router_fifo #(.DEPTH(FIFO_DEPTH), .T(cache_rsp_pkg)) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push[d]),
      .pop  (pop[d]),
      .din  (s_pld),
      .full (full[d]),
      .empty(empty[d]),
      .head (head[d])
    );
  end
  always_comb err_d = s_vld & ~legal;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err_vld = err_q;
endmodule

// File: tb/tb_toy_cache_rsp_router.sv
// tb_toy_cache_rsp_router: directed self-checking bench for toy_cache_rsp_router
module tb_toy_cache_rsp_router;
  import toy_cache_rsp_router_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic s_vld;
  logic s_rdy;
  cache_rsp_pkg s_pld;
  logic [2:0] v_m_vld;
  logic [2:0] v_m_rdy;
  cache_rsp_pkg [2:0] v_m_pld;
  logic err_vld;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  toy_cache_rsp_router #(.NUM_DST(3), .FIFO_DEPTH(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_vld  (s_vld),
    .s_rdy  (s_rdy),
    .s_pld  (s_pld),
    .v_m_vld(v_m_vld),
    .v_m_rdy(v_m_rdy),
    .v_m_pld(v_m_pld),
    .err_vld(err_vld)
  );
  function automatic cache_rsp_pkg mk(input logic [1:0] id, input logic [63:0] d);
    cache_rsp_pkg p;
    p = '0;
    p.src_id = id;
    p.rd_data = d;
    p.lsu_tag = d[3:0];
    return p;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b1;
    s_vld = 1'b0;
    s_pld = mk(2'd0, 64'h0);
    v_m_rdy = 3'b000;
    repeat (2) step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL rst_vld got=%b exp=000", v_m_vld); end
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL rst_s_rdy got=%b exp=1", s_rdy); end
    checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_vld); end
    rst_n = 1'b0;
    step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL post_rst_vld got=%b exp=000", v_m_vld); end
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_s_rdy got=%b exp=1", s_rdy); end
  endtask
  task automatic test_basic();
    v_m_rdy = 3'b111;
    s_vld = 1'b1;
    s_pld = mk(2'd1, 64'hA5);
    #1;
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL basic_s_rdy got=%b exp=1", s_rdy); end
`ifdef TOY_RSP_ROUTER_BYPASS_EN
    checks++; if (v_m_vld !== 3'b010) begin failures++; $display("FAIL basic_byp_vld got=%b exp=010", v_m_vld); end
    checks++; if (v_m_pld[1].rd_data !== 64'hA5) begin failures++; $display("FAIL basic_byp_pld got=%0h exp=a5", v_m_pld[1].rd_data); end
    step();
    s_vld = 1'b0;
    #1;
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL basic_byp_after got=%b exp=000", v_m_vld); end
`else
    step();
    s_vld = 1'b0;
    checks++; if (v_m_vld !== 3'b010) begin failures++; $display("FAIL basic_vld got=%b exp=010", v_m_vld); end
    checks++; if (v_m_pld[1].rd_data !== 64'hA5) begin failures++; $display("FAIL basic_pld got=%0h exp=a5", v_m_pld[1].rd_data); end
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL basic_s_rdy2 got=%b exp=1", s_rdy); end
    step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL basic_drained got=%b exp=000", v_m_vld); end
`endif
  endtask
  task automatic test_stall();
    v_m_rdy = 3'b110;
    s_vld = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_pld = mk(2'd0, 64'h10 + 64'(k));
      #1;
      checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL stall_acc%0d got=%b exp=1", k, s_rdy); end
      step();
    end
    s_pld = mk(2'd0, 64'h12);
    #1;
    checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL stall_full got=%b exp=0", s_rdy); end
    step();
    checks++; if (v_m_pld[0].rd_data !== 64'h10) begin failures++; $display("FAIL stall_head got=%0h exp=10", v_m_pld[0].rd_data); end
    v_m_rdy = 3'b111;
    #1;
    checks++; if (s_rdy !== 1'b0) begin failures++; $display("FAIL stall_full_pop got=%b exp=0", s_rdy); end
    step();
    checks++; if (v_m_pld[0].rd_data !== 64'h11) begin failures++; $display("FAIL stall_d1 got=%0h exp=11", v_m_pld[0].rd_data); end
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL stall_reopen got=%b exp=1", s_rdy); end
    step();
    s_vld = 1'b0;
    checks++; if (v_m_vld[0] !== 1'b1 || v_m_pld[0].rd_data !== 64'h12) begin failures++; $display("FAIL stall_d2 got=%b/%0h exp=1/12", v_m_vld[0], v_m_pld[0].rd_data); end
    step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL stall_empty got=%b exp=000", v_m_vld); end
  endtask
  task automatic test_hol();
    v_m_rdy = 3'b000;
    s_vld = 1'b1;
    s_pld = mk(2'd0, 64'h20);
    step();
    s_pld = mk(2'd0, 64'h21);
    step();
    s_pld = mk(2'd2, 64'h30);
    #1;
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL hol_s_rdy got=%b exp=1", s_rdy); end
    step();
    s_vld = 1'b0;
    checks++; if (v_m_vld !== 3'b101) begin failures++; $display("FAIL hol_vld got=%b exp=101", v_m_vld); end
    checks++; if (v_m_pld[2].rd_data !== 64'h30) begin failures++; $display("FAIL hol_pld2 got=%0h exp=30", v_m_pld[2].rd_data); end
    checks++; if (v_m_pld[0].rd_data !== 64'h20) begin failures++; $display("FAIL hol_pld0 got=%0h exp=20", v_m_pld[0].rd_data); end
    v_m_rdy = 3'b111;
    repeat (3) step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL hol_drain got=%b exp=000", v_m_vld); end
  endtask
  task automatic test_err();
    v_m_rdy = 3'b111;
    s_vld = 1'b1;
    s_pld = mk(2'd3, 64'h55);
    #1;
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL err_s_rdy got=%b exp=1", s_rdy); end
    checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL err_early got=%b exp=0", err_vld); end
    step();
    s_vld = 1'b0;
    checks++; if (err_vld !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", err_vld); end
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL err_vld_out got=%b exp=000", v_m_vld); end
    step();
    checks++; if (err_vld !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_vld); end
  endtask
  task automatic test_stream();
    v_m_rdy = 3'b010;
    for (int k = 0; k < 20; k++) begin
      s_vld = 1'b1;
      s_pld = mk(2'd1, 64'(k));
      #1;
      checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL stream_s_rdy%0d got=%b exp=1", k, s_rdy); end
      step();
      checks++; if (v_m_vld !== 3'b010 || v_m_pld[1].rd_data !== 64'(k)) begin failures++; $display("FAIL stream_d%0d got=%b/%0h exp=010/%0h", k, v_m_vld, v_m_pld[1].rd_data, k); end
    end
    s_vld = 1'b0;
    step();
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL stream_end got=%b exp=000", v_m_vld); end
  endtask
  task automatic test_mid_reset();
    v_m_rdy = 3'b000;
    s_vld = 1'b1;
    s_pld = mk(2'd0, 64'h40);
    step();
    s_pld = mk(2'd0, 64'h41);
    step();
    s_vld = 1'b0;
    #1;
    checks++; if (s_rdy !== 1'b0 || v_m_vld !== 3'b001) begin failures++; $display("FAIL mrst_pre got=%b/%b exp=0/001", s_rdy, v_m_vld); end
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (v_m_vld !== 3'b000) begin failures++; $display("FAIL mrst_async_vld got=%b exp=000", v_m_vld); end
    checks++; if (s_rdy !== 1'b1) begin failures++; $display("FAIL mrst_async_s_rdy got=%b exp=1", s_rdy); end
    step();
    rst_n = 1'b0;
    step();
    checks++; if (v_m_vld !== 3'b000 || s_rdy !== 1'b1) begin failures++; $display("FAIL mrst_after got=%b/%b exp=000/1", v_m_vld, s_rdy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_hol();
    test_err();
    test_stream();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
